// File: rtl/sd_route_pkg.sv
// rtl/sd_route_pkg.sv - shared types and default constants for the SD route controller
// Purpose: state enum and parameter defaults used by sd_route_ctrl and sd_act_timer.
// Ports: none (package).
package sd_route_pkg;

  typedef enum logic [1:0] {
    PHYS    = 2'd0,
    VIRT    = 2'd1,
    PENDING = 2'd2,
    GUARD   = 2'd3
  } sd_route_state_t;

  localparam int unsigned DEF_IDLE_CYCLES  = 16;
  localparam int unsigned DEF_GUARD_CYCLES = 8;
  localparam int unsigned DEF_ACT_TIMEOUT  = 1000000;

endpackage

// File: rtl/sd_act_timer.sv
// rtl/sd_act_timer.sv - SPI activity detector with saturating hold counter
// Purpose: flags SPI activity for ACT_TIMEOUT clocks after the last MOSI/MISO toggle.
// Built only when SD_ROUTE_ACT_LED_EN is defined.
// Ports:
//   i_clk      - clock, rising edge
//   i_reset_n  - synchronous active-low reset
//   i_mosi     - MOSI as driven by the core
//   i_miso     - MISO as returned to the core
//   o_act      - 1 while the hold counter has not yet saturated
`ifdef SD_ROUTE_ACT_LED_EN
module sd_act_timer
  import sd_route_pkg::*;
#(
  parameter int unsigned ACT_TIMEOUT = DEF_ACT_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_mosi,
  input  logic i_miso,
  output logic o_act
);

  localparam int unsigned AW = $clog2(ACT_TIMEOUT) + 1;
  localparam logic [AW-1:0] ACT_MAX = AW'(ACT_TIMEOUT);

  logic          r_mosi_q;
  logic          r_miso_q;
  logic [AW-1:0] r_act_cnt;
  logic          w_toggle;

  assign w_toggle = (i_mosi != r_mosi_q) | (i_miso != r_miso_q);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_mosi_q  <= 1'b0;
      r_miso_q  <= 1'b0;
      // Start saturated so the indicators are dark out of reset.
      r_act_cnt <= ACT_MAX;
    end else begin
      r_mosi_q <= i_mosi;
      r_miso_q <= i_miso;
      if (w_toggle) begin
        r_act_cnt <= '0;
      end else if (r_act_cnt != ACT_MAX) begin
        r_act_cnt <= r_act_cnt + 1'b1;
      end
    end
  end

  assign o_act = (r_act_cnt < ACT_MAX);

endmodule
`endif

// File: rtl/sd_route_ctrl.sv
// rtl/sd_route_ctrl.sv - routes the core SD SPI port to the physical slot or the virtual card
// Purpose: source switches are requested by image mount events and applied only after the
// SPI bus has been idle; a guard window with both card selects deasserted separates routes.
// Optional macro SD_ROUTE_ACT_LED_EN: when defined, LEDs show SPI toggle activity with a
// hold time; when undefined, LEDs show the selected side's chip select.
// Ports:
//   i_clk_sys, i_reset_n                - clock, synchronous active-low reset
//   i_img_mounted, i_img_present        - mount pulse and image-present flag
//   i_core_sck/mosi/cs_n, o_core_miso   - SPI master from the core
//   o_phys_sck/mosi/cs_n, i_phys_miso   - physical slot SPI
//   o_virt_sck/mosi/cs_n, i_virt_miso   - virtual card SPI
//   o_vsd_sel                           - 1 when the virtual card is the active route
//   o_switching                         - high in PENDING and GUARD
//   o_led_virt, o_led_phys              - activity indicators
module sd_route_ctrl
  import sd_route_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES  = DEF_IDLE_CYCLES,
  parameter int unsigned GUARD_CYCLES = DEF_GUARD_CYCLES,
  parameter int unsigned ACT_TIMEOUT  = DEF_ACT_TIMEOUT
) (
  input  logic i_clk_sys,
  input  logic i_reset_n,
  input  logic i_img_mounted,
  input  logic i_img_present,
  input  logic i_core_sck,
  input  logic i_core_mosi,
  input  logic i_core_cs_n,
  output logic o_core_miso,
  output logic o_phys_sck,
  output logic o_phys_mosi,
  output logic o_phys_cs_n,
  input  logic i_phys_miso,
  output logic o_virt_sck,
  output logic o_virt_mosi,
  output logic o_virt_cs_n,
  input  logic i_virt_miso,
  output logic o_vsd_sel,
  output logic o_switching,
  output logic o_led_virt,
  output logic o_led_phys
);

  localparam int unsigned IW = $clog2(IDLE_CYCLES) + 1;
  localparam int unsigned GW = $clog2(GUARD_CYCLES) + 1;
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_CYCLES - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

  sd_route_state_t r_state;
  sd_route_state_t w_state_nxt;
  logic            r_vsd_sel;
  logic            w_vsd_sel_nxt;
  logic            r_target;
  logic [IW-1:0]   r_idle_cnt;
  logic [IW-1:0]   w_idle_nxt;
  logic [GW-1:0]   r_guard_cnt;
  logic [GW-1:0]   w_guard_nxt;
  logic            w_core_miso;

  always_ff @(posedge i_clk_sys) begin
    if (!i_reset_n) begin
      r_state     <= PHYS;
      r_vsd_sel   <= 1'b0;
      r_target    <= 1'b0;
      r_idle_cnt  <= '0;
      r_guard_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_vsd_sel   <= w_vsd_sel_nxt;
      r_idle_cnt  <= w_idle_nxt;
      r_guard_cnt <= w_guard_nxt;
      // Every mount event overwrites the request, so the latest one wins.
      if (i_img_mounted) begin
        r_target <= i_img_present;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_vsd_sel_nxt = r_vsd_sel;
    w_idle_nxt    = '0;
    w_guard_nxt   = '0;
    case (r_state)
      PHYS, VIRT: begin
        if (r_target != r_vsd_sel) begin
          w_state_nxt = PENDING;
        end
      end
      PENDING: begin
        // A retracted request drops straight back to the current route.
        if (r_target == r_vsd_sel) begin
          w_state_nxt = r_vsd_sel ? VIRT : PHYS;
        end else if (!i_core_cs_n) begin
          w_idle_nxt = '0;
        end else if (r_idle_cnt == IDLE_LAST) begin
          w_state_nxt = GUARD;
        end else begin
          w_idle_nxt = r_idle_cnt + 1'b1;
        end
      end
      GUARD: begin
        // The route is committed from whatever target holds at the end of the window;
        // a mount arriving during GUARD is picked up by the stable-state compare after.
        if (r_guard_cnt == GUARD_LAST) begin
          w_vsd_sel_nxt = r_target;
          w_state_nxt   = r_target ? VIRT : PHYS;
        end else begin
          w_guard_nxt = r_guard_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = PHYS;
      end
    endcase
  end

  always_comb begin
    o_phys_sck  = 1'b0;
    o_phys_mosi = 1'b0;
    o_phys_cs_n = 1'b1;
    o_virt_sck  = 1'b0;
    o_virt_mosi = 1'b0;
    o_virt_cs_n = 1'b1;
    w_core_miso = 1'b1;
    if (r_state != GUARD) begin
      if (r_vsd_sel) begin
        o_virt_sck  = i_core_sck;
        o_virt_mosi = i_core_mosi;
        o_virt_cs_n = i_core_cs_n;
        w_core_miso = i_virt_miso;
      end else begin
        o_phys_sck  = i_core_sck;
        o_phys_mosi = i_core_mosi;
        o_phys_cs_n = i_core_cs_n;
        w_core_miso = i_phys_miso;
      end
    end
  end

  assign o_core_miso = w_core_miso;
  assign o_vsd_sel   = r_vsd_sel;
  assign o_switching = (r_state == PENDING) || (r_state == GUARD);

`ifdef SD_ROUTE_ACT_LED_EN
  logic w_act;

  sd_act_timer #(
    .ACT_TIMEOUT(ACT_TIMEOUT)
  ) u_act_timer (
    .i_clk    (i_clk_sys),
    .i_reset_n(i_reset_n),
    .i_mosi   (i_core_mosi),
    .i_miso   (w_core_miso),
    .o_act    (w_act)
  );

  assign o_led_virt = w_act & r_vsd_sel;
  assign o_led_phys = w_act & ~r_vsd_sel;
`else
  // The hold time only matters to the activity timer; keep the parameter referenced.
  logic w_unused_act;
  assign w_unused_act = (ACT_TIMEOUT == 0);

  assign o_led_virt = r_vsd_sel & ~o_virt_cs_n;
  assign o_led_phys = ~r_vsd_sel & ~o_phys_cs_n;
`endif

endmodule

// File: tb/tb_sd_route_ctrl.sv
// tb/tb_sd_route_ctrl.sv - self-checking bench for sd_route_ctrl
module tb_sd_route_ctrl;

  localparam int IDLE  = 16;
  localparam int GUARD = 8;
  localparam int ACT   = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, img_mounted, img_present;
  logic core_sck, core_mosi, core_cs_n, phys_miso, virt_miso;
  logic core_miso, phys_sck, phys_mosi, phys_cs_n;
  logic virt_sck, virt_mosi, virt_cs_n;
  logic vsd_sel, switching, led_virt, led_phys;

  sd_route_ctrl #(
    .IDLE_CYCLES (IDLE),
    .GUARD_CYCLES(GUARD),
    .ACT_TIMEOUT (ACT)
  ) dut (
    .i_clk_sys    (clk),
    .i_reset_n    (reset_n),
    .i_img_mounted(img_mounted),
    .i_img_present(img_present),
    .i_core_sck   (core_sck),
    .i_core_mosi  (core_mosi),
    .i_core_cs_n  (core_cs_n),
    .o_core_miso  (core_miso),
    .o_phys_sck   (phys_sck),
    .o_phys_mosi  (phys_mosi),
    .o_phys_cs_n  (phys_cs_n),
    .i_phys_miso  (phys_miso),
    .o_virt_sck   (virt_sck),
    .o_virt_mosi  (virt_mosi),
    .o_virt_cs_n  (virt_cs_n),
    .i_virt_miso  (virt_miso),
    .o_vsd_sel    (vsd_sel),
    .o_switching  (switching),
    .o_led_virt   (led_virt),
    .o_led_phys   (led_phys)
  );

  int tests = 0;
  int fails = 0;
  int n = 0;

  // Reference model kept as timestamps: when the request began, when CS was last low,
  // and when the guard window ends.
  bit m_sel, m_target, m_pend, m_guard, m_has_tog, m_prev_mosi, m_prev_miso;
  int m_pstart, m_last_low, m_gend, m_last_tog;

  function automatic void model_reset();
    m_sel = 0; m_target = 0; m_pend = 0; m_guard = 0;
    m_has_tog = 0; m_prev_mosi = 0; m_prev_miso = 0;
    m_pstart = 0; m_last_low = -1000; m_gend = 0; m_last_tog = 0;
  endfunction

  // {phys_sck, phys_mosi, phys_cs_n, virt_sck, virt_mosi, virt_cs_n, core_miso}
  function automatic logic [6:0] exp_route();
    if (m_guard) return 7'b001_001_1;
    if (m_sel)   return {3'b001, core_sck, core_mosi, core_cs_n, virt_miso};
    return {core_sck, core_mosi, core_cs_n, 3'b001, phys_miso};
  endfunction

  function automatic void model_edge();
    logic [6:0] r;
    bit told, cur_miso;
    int since;
    if (!reset_n) begin
      model_reset();
      return;
    end
    r = exp_route();
    cur_miso = r[0];
    if ((core_mosi != m_prev_mosi) || (cur_miso != m_prev_miso)) begin
      m_has_tog = 1; m_last_tog = n;
    end
    m_prev_mosi = core_mosi;
    m_prev_miso = cur_miso;
    told = m_target;
    if (m_guard) begin
      if (n == m_gend) begin
        m_sel = told; m_guard = 0;
      end
    end else if (m_pend) begin
      if (told == m_sel) begin
        m_pend = 0;
      end else if (!core_cs_n) begin
        m_last_low = n;
      end else begin
        since = n - ((m_pstart > m_last_low) ? m_pstart : m_last_low);
        if (since == IDLE) begin
          m_pend = 0; m_guard = 1; m_gend = n + GUARD;
        end
      end
    end else if (told != m_sel) begin
      m_pend = 1; m_pstart = n;
    end
    if (img_mounted) m_target = img_present;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic check_all();
    logic [6:0] r;
    logic [1:0] leds;
    bit act;
    r = exp_route();
`ifdef SD_ROUTE_ACT_LED_EN
    act  = m_has_tog && ((n - m_last_tog) < ACT);
    leds = {act & m_sel, act & ~m_sel};
`else
    act  = 0;
    leds = {m_sel & ~r[1], ~m_sel & ~r[4]};
`endif
    chk("vsd_sel", {31'd0, vsd_sel}, {31'd0, m_sel});
    chk("switching", {31'd0, switching}, {31'd0, m_pend | m_guard});
    chk("route", {25'd0, phys_sck, phys_mosi, phys_cs_n, virt_sck, virt_mosi, virt_cs_n,
                  core_miso}, {25'd0, r});
    chk("leds", {30'd0, led_virt, led_phys}, {30'd0, leds});
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    model_edge();
    #1;
    check_all();
  endtask

  task automatic mount(input logic p);
    img_mounted = 1; img_present = p;
    step();
    img_mounted = 0; img_present = 0;
  endtask

  task automatic wait_sel(input logic v, output int cnt);
    cnt = 0;
    while (vsd_sel !== v && cnt < 300) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    int c, hi, lit;
    bit changed;
    model_reset();
    reset_n = 0; img_mounted = 0; img_present = 0;
    core_sck = 0; core_mosi = 0; core_cs_n = 1; phys_miso = 0; virt_miso = 0;
    repeat (3) step();
    reset_n = 1;
    step();
    chk("reset_vsd_sel", {31'd0, vsd_sel}, 32'd0);
    chk("reset_virt_cs", {31'd0, virt_cs_n}, 32'd1);
    chk("reset_leds", {30'd0, led_virt, led_phys}, 32'd0);
    core_cs_n = 0;
    step();
    chk("reset_phys_cs_follow", {31'd0, phys_cs_n}, 32'd0);
    core_cs_n = 1;
    step();
    chk("reset_phys_cs_high", {31'd0, phys_cs_n}, 32'd1);

    // Idle mount: switch lands IDLE+GUARD+2 clocks after the pulse.
    mount(1);
    wait_sel(1, c);
    chk("idle_latency", c + 1, IDLE + GUARD + 2);
    mount(0);
    wait_sel(0, c);
    chk("unmount_latency", c + 1, IDLE + GUARD + 2);

    // Busy deferral: no switch while CS is held low.
    core_cs_n = 0;
    mount(1);
    repeat (99) step();
    chk("busy_hold_sel", {31'd0, vsd_sel}, 32'd0);
    chk("busy_phys_cs", {31'd0, phys_cs_n}, 32'd0);
    core_cs_n = 1;
    wait_sel(1, c);
    chk("busy_latency", c, IDLE + GUARD);

    // Retraction inside PENDING: route never changes.
    changed = 0;
    mount(0);
    if (vsd_sel !== 1'b1) changed = 1;
    repeat (4) begin
      step();
      if (vsd_sel !== 1'b1) changed = 1;
    end
    mount(1);
    repeat (40) begin
      step();
      if (vsd_sel !== 1'b1) changed = 1;
    end
    chk("retract_sel_stable", {31'd0, changed}, 32'd0);
    chk("retract_not_switching", {31'd0, switching}, 32'd0);

    // Activity indicators in VIRT.
    repeat (ACT + 5) step();
`ifdef SD_ROUTE_ACT_LED_EN
    chk("act_quiet", {31'd0, led_virt}, 32'd0);
    core_mosi = ~core_mosi;
    hi = 0; lit = 0;
    for (int i = 0; i < 3 * ACT; i++) begin
      step();
      if (led_virt === 1'b1) hi++;
      if (led_phys !== 1'b0) lit++;
    end
    chk("act_len", hi, ACT);
    chk("act_phys_dark", lit, 0);
`else
    core_cs_n = 0;
    step();
    chk("led_virt_cs", {31'd0, led_virt}, 32'd1);
    chk("led_phys_cs", {31'd0, led_phys}, 32'd0);
    core_cs_n = 1;
    step();
    chk("led_virt_idle", {31'd0, led_virt}, 32'd0);
`endif

    // Randomized traffic and mount events against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) core_cs_n = ~core_cs_n;
      core_sck    = 1'($urandom_range(0, 1));
      core_mosi   = 1'($urandom_range(0, 1));
      phys_miso   = 1'($urandom_range(0, 1));
      virt_miso   = 1'($urandom_range(0, 1));
      img_mounted = ($urandom_range(0, 29) == 0);
      img_present = 1'($urandom_range(0, 1));
      step();
    end
    img_mounted = 0; img_present = 0; core_cs_n = 1;
    repeat (60) step();

    // Reset in the middle of GUARD.
    mount(~m_sel);
    c = 0;
    while (!m_guard && c < 200) begin
      step();
      c++;
    end
    chk("guard_reached_cs", {30'd0, phys_cs_n, virt_cs_n}, 32'd3);
    chk("guard_reached_miso", {31'd0, core_miso}, 32'd1);
    repeat (2) step();
    reset_n = 0; core_cs_n = 0;
    step();
    chk("rst_sel", {31'd0, vsd_sel}, 32'd0);
    chk("rst_switching", {31'd0, switching}, 32'd0);
    chk("rst_phys_cs", {31'd0, phys_cs_n}, 32'd0);
    chk("rst_virt_cs", {31'd0, virt_cs_n}, 32'd1);
    reset_n = 1; core_cs_n = 1;
    repeat (30) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
